array_3d_sweep_ctrl: RTL and testbench

- Sequencer that fills a packed 3D register array `[DIM_I][DIM_J][DIM_K][DW]` one element per enabled cycle.
- Walks indices i→j→k with k innermost and writes `base + i + j + k` into each element.
- Exposes the live array, the current index and a start/busy/done handshake.
- Used as the reusable stimulus/init engine for packed-array waveform examples and as a hardware array initialiser.

---
 rtl/array_3d_pkg.sv | 29 ++
 rtl/array_3d_idx_cnt.sv | 84 ++++++++
 rtl/array_3d_sweep_ctrl.sv | 118 +++++++++++
 tb/tb_array_3d_sweep_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/array_3d_pkg.sv
// ============================================================================
// Module   : array_3d_pkg
// Purpose  : Shared types, default dimensions and the index-width helper for
//            the 3D array sweep controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package array_3d_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    localparam int DEF_DIM_I = 4;
    localparam int DEF_DIM_J = 3;
    localparam int DEF_DIM_K = 2;
    localparam int DEF_DW    = 8;

    // A dimension of 1 still gets a 1-bit index so ports never collapse to zero width.
    function automatic int idx_w(input int dim);
        return (dim < 2) ? 1 : $clog2(dim);
    endfunction

endpackage

`default_nettype wire

// File: rtl/array_3d_idx_cnt.sv
// ============================================================================
// Module   : array_3d_idx_cnt
// Purpose  : Nested i->j->k wrap counter (k innermost) with clear and step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_3d_idx_cnt
    import array_3d_pkg::*;
#(
    parameter  int DIM_I = DEF_DIM_I,
    parameter  int DIM_J = DEF_DIM_J,
    parameter  int DIM_K = DEF_DIM_K,
    localparam int IW_I  = idx_w(DIM_I),
    localparam int IW_J  = idx_w(DIM_J),
    localparam int IW_K  = idx_w(DIM_K)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    output logic [IW_I-1:0] idx_i,
    output logic [IW_J-1:0] idx_j,
    output logic [IW_K-1:0] idx_k,
    output logic            last
);

    localparam logic [IW_I-1:0] I_MAX = IW_I'(DIM_I - 1);
    localparam logic [IW_J-1:0] J_MAX = IW_J'(DIM_J - 1);
    localparam logic [IW_K-1:0] K_MAX = IW_K'(DIM_K - 1);

    logic [IW_I-1:0] idx_i_q, idx_i_d;
    logic [IW_J-1:0] idx_j_q, idx_j_d;
    logic [IW_K-1:0] idx_k_q, idx_k_d;
    logic            w_i_max, w_j_max, w_k_max;

    assign w_i_max = (idx_i_q == I_MAX);
    assign w_j_max = (idx_j_q == J_MAX);
    assign w_k_max = (idx_k_q == K_MAX);

    always_comb begin
        idx_i_d = idx_i_q;
        idx_j_d = idx_j_q;
        idx_k_d = idx_k_q;
        if (clr) begin
            idx_i_d = '0;
            idx_j_d = '0;
            idx_k_d = '0;
        end else if (inc) begin
            // Stepping past the last element wraps every digit back to zero.
            if (!w_k_max) begin
                idx_k_d = idx_k_q + IW_K'(1);
            end else begin
                idx_k_d = '0;
                if (!w_j_max) begin
                    idx_j_d = idx_j_q + IW_J'(1);
                end else begin
                    idx_j_d = '0;
                    idx_i_d = w_i_max ? '0 : idx_i_q + IW_I'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_i_q <= '0;
            idx_j_q <= '0;
            idx_k_q <= '0;
        end else begin
            idx_i_q <= idx_i_d;
            idx_j_q <= idx_j_d;
            idx_k_q <= idx_k_d;
        end
    end

    assign idx_i = idx_i_q;
    assign idx_j = idx_j_q;
    assign idx_k = idx_k_q;
    assign last  = w_i_max & w_j_max & w_k_max;

endmodule

`default_nettype wire

// File: rtl/array_3d_sweep_ctrl.sv
// ============================================================================
// Module   : array_3d_sweep_ctrl
// Purpose  : Fills a packed 3D array with base+i+j+k, one element per enabled
//            cycle. Define ARRAY_3D_SWEEP_CLEAR_EN to zero the array on start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_3d_sweep_ctrl
    import array_3d_pkg::*;
#(
    parameter  int DIM_I = DEF_DIM_I,
    parameter  int DIM_J = DEF_DIM_J,
    parameter  int DIM_K = DEF_DIM_K,
    parameter  int DW    = DEF_DW,
    localparam int IW_I  = idx_w(DIM_I),
    localparam int IW_J  = idx_w(DIM_J),
    localparam int IW_K  = idx_w(DIM_K)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [DW-1:0]                               base,
    input  logic                                        step_en,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        wr_en,
    output logic [IW_I-1:0]                             idx_i,
    output logic [IW_J-1:0]                             idx_j,
    output logic [IW_K-1:0]                             idx_k,
    output logic [DIM_I-1:0][DIM_J-1:0][DIM_K-1:0][DW-1:0] array_o
);

    sweep_state_t state_q, state_d;
    logic [DW-1:0] base_q, base_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DIM_I-1:0][DIM_J-1:0][DIM_K-1:0][DW-1:0] array_q, array_d;

    logic          w_accept;
    logic          w_wr;
    logic          w_last;
    logic [DW+1:0] w_sum;

    assign w_accept = (state_q == IDLE) & start;
    assign w_wr     = (state_q == RUN) & step_en;

    array_3d_idx_cnt #(
        .DIM_I (DIM_I),
        .DIM_J (DIM_J),
        .DIM_K (DIM_K)
    ) u_idx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_accept),
        .inc   (w_wr),
        .idx_i (idx_i),
        .idx_j (idx_j),
        .idx_k (idx_k),
        .last  (w_last)
    );

    // Two guard bits keep the sum exact before it is folded back to DW bits.
    assign w_sum = (DW+2)'(base_q) + (DW+2)'(idx_i) + (DW+2)'(idx_j) + (DW+2)'(idx_k);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        array_d = array_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    base_d  = base;
`ifdef ARRAY_3D_SWEEP_CLEAR_EN
                    array_d = '0;
`endif
                end
            end
            RUN: begin
                if (step_en) begin
                    array_d[idx_i][idx_j][idx_k] = w_sum[DW-1:0];
                    if (w_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            array_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            array_q <= array_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_en   = w_wr;
    assign array_o = array_q;

endmodule

`default_nettype wire

// File: tb/tb_array_3d_sweep_ctrl.sv
// ============================================================================
// Module   : tb_array_3d_sweep_ctrl
// Purpose  : Randomised self-checking bench for array_3d_sweep_ctrl against a
//            position-counter reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_3d_sweep_ctrl;

    localparam int DI = 4;
    localparam int DJ = 3;
    localparam int DK = 2;
    localparam int DW = 8;
    localparam int N  = DI * DJ * DK;
    localparam int AW = N * DW;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          step_en = 1'b0;
    logic [DW-1:0] base    = '0;
    logic          busy, done, wr_en;
    logic [1:0]    idx_i, idx_j;
    logic [0:0]    idx_k;
    logic [DI-1:0][DJ-1:0][DK-1:0][DW-1:0] array_o;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0, done_cnt = 0, busy_cnt = 0;

    always #5 clk = ~clk;

    array_3d_sweep_ctrl #(
        .DIM_I (DI),
        .DIM_J (DJ),
        .DIM_K (DK),
        .DW    (DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .base    (base),
        .step_en (step_en),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .idx_i   (idx_i),
        .idx_j   (idx_j),
        .idx_k   (idx_k),
        .array_o (array_o)
    );

    // Reference: a linear position 0..N-1 decomposed into (i,j,k) arithmetically.
    logic [DW-1:0] m_arr [DI][DJ][DK];
    bit            m_run, m_done;
    int            m_pos;
    logic [DW-1:0] m_base;

    task automatic m_clear();
        for (int i = 0; i < DI; i++)
            for (int j = 0; j < DJ; j++)
                for (int k = 0; k < DK; k++)
                    m_arr[i][j][k] = '0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_pos = 0; m_base = '0;
            m_clear();
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_pos = 0; m_base = base;
`ifdef ARRAY_3D_SWEEP_CLEAR_EN
                m_clear();
`endif
            end
        end else if (step_en) begin
            m_arr[m_pos / (DJ*DK)][(m_pos / DK) % DJ][m_pos % DK] =
                DW'(int'(m_base) + m_pos / (DJ*DK) + (m_pos / DK) % DJ + m_pos % DK);
            m_pos++;
            if (m_pos == N) begin
                m_run = 0; m_done = 1; m_pos = 0;
            end
        end
    end

    function automatic logic [AW-1:0] m_packed();
        logic [AW-1:0] r = '0;
        for (int i = 0; i < DI; i++)
            for (int j = 0; j < DJ; j++)
                for (int k = 0; k < DK; k++)
                    r[((i*DJ + j)*DK + k)*DW +: DW] = m_arr[i][j][k];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy",  AW'(busy),  AW'(m_run));
        chk("done",  AW'(done),  AW'(m_done));
        chk("wr_en", AW'(wr_en), AW'(m_run & step_en));
        chk("idx",   AW'({idx_i, idx_j, idx_k}),
            AW'({2'(m_pos / (DJ*DK)), 2'((m_pos / DK) % DJ), 1'(m_pos % DK)}));
        chk("array", array_o, m_packed());
        if (wr_en) wr_cnt++;
        if (done)  done_cnt++;
        if (busy)  busy_cnt++;
    end

    // mode 0: step_en high; 1: alternating starting high; 2: random.
    task automatic sweep(input logic [DW-1:0] b, input int mode, input bit noise,
                         input bit chk_t0, input logic [DW-1:0] exp_t0);
        bit fin = 0;
        @(posedge clk); #1;
        start = 1; base = b; step_en = 1;
        @(posedge clk); #1;
        start = 0;
        if (chk_t0) chk("t0_elem_3_2_1", AW'(array_o[3][2][1]), AW'(exp_t0));
        for (int c = 1; c <= 200; c++) begin
            case (mode)
                0:       step_en = 1;
                1:       step_en = c[0];
                default: step_en = 1'($urandom_range(0, 1));
            endcase
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                base  = DW'($urandom);
            end
            @(posedge clk); #1;
            if (done) begin fin = 1; break; end
        end
        if (noise) begin
            start = 1; base = DW'($urandom);
        end
        @(posedge clk); #1;
        start = 0;
        if (!fin) begin
            total++; bad++;
            $display("FAIL sweep_timeout: got no done expected done within 200 cycles");
        end
    endtask

    initial begin
        int w0, d0, b0;
        logic [AW-1:0] snap1;
        bit hit;

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_array", array_o, '0);
        chk("rst_busy",  AW'(busy), '0);

        // base 0, step held high
        w0 = wr_cnt; d0 = done_cnt; b0 = busy_cnt;
        sweep(8'h00, 0, 0, 0, 8'h00);
        chk("t1_writes", AW'(wr_cnt - w0), AW'(24));
        chk("t1_dones",  AW'(done_cnt - d0), AW'(1));
        chk("t1_busy",   AW'(busy_cnt - b0), AW'(24));
        chk("t1_e321",   AW'(array_o[3][2][1]), AW'(8'd6));
        chk("t1_e000",   AW'(array_o[0][0][0]), AW'(8'd0));
        chk("t1_e210",   AW'(array_o[2][1][0]), AW'(8'd3));
        chk("t1_model",  AW'(m_arr[3][2][1]),   AW'(8'd6));
        snap1 = array_o;

        // wrap-around of the 8-bit sum
        sweep(8'hFE, 0, 0, 0, 8'h00);
        chk("t2_e000", AW'(array_o[0][0][0]), AW'(8'hFE));
        chk("t2_e101", AW'(array_o[1][0][1]), AW'(8'h00));
        chk("t2_e321", AW'(array_o[3][2][1]), AW'(8'h04));

        // alternating step_en: writes on odd RUN cycles, 24th on cycle 47
        w0 = wr_cnt; b0 = busy_cnt;
        sweep(8'h00, 1, 0, 0, 8'h00);
        chk("t3_writes", AW'(wr_cnt - w0), AW'(24));
        chk("t3_busy",   AW'(busy_cnt - b0), AW'(47));
        chk("t3_same",   array_o, snap1);

        // start/base noise during RUN and DONE
        d0 = done_cnt;
        sweep(8'h5A, 2, 1, 0, 8'h00);
        @(posedge clk); #1;
        chk("t4_dones", AW'(done_cnt - d0), AW'(1));

        // reset after the tenth write
        w0 = wr_cnt; d0 = done_cnt; hit = 0;
        @(posedge clk); #1;
        start = 1; base = 8'h33; step_en = 1;
        @(posedge clk); #1;
        start = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (wr_cnt - w0 >= 10) begin hit = 1; break; end
        end
        if (!hit) begin
            total++; bad++;
            $display("FAIL t5_wait: got %0d writes expected 10", wr_cnt - w0);
        end
        rst_n = 0;
        #1;
        chk("t5_array", array_o, '0);
        chk("t5_busy",  AW'(busy), '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("t5_nodone", AW'(done_cnt - d0), '0);
        d0 = done_cnt;
        sweep(8'h10, 0, 0, 0, 8'h00);
        chk("t5_dones", AW'(done_cnt - d0), AW'(1));

        // second sweep: clear-on-start vs. persisting contents
`ifdef ARRAY_3D_SWEEP_CLEAR_EN
        sweep(8'h01, 0, 0, 1, 8'h00);
`else
        sweep(8'h01, 0, 0, 1, 8'h16);
`endif
        chk("t6_e321", AW'(array_o[3][2][1]), AW'(8'h07));

        // random sweeps
        for (int r = 0; r < 6; r++) begin
            d0 = done_cnt;
            sweep(DW'($urandom), 2, 1'($urandom_range(0, 1)), 0, 8'h00);
            chk("rnd_dones", AW'(done_cnt - d0), AW'(1));
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
